eflags_cond_unit: RTL

Owns the architectural RFLAGS register and is the consumer of the ALU's flag-write interface (eflags, eflags_update). It supplies the current flags back to the ALU as a source, tracks in-flight flag writers, and resolves condition-code requests for Jcc/SETcc/CMOVcc micro-ops over a valid/ready handshake. It sits between decode/issue, the ALU and the branch/writeback logic.

---
 rtl/eflags_cond_unit_pkg.sv | 58 +++++
 rtl/eflags_cond_unit_cond_eval.sv | 60 ++++++
 rtl/eflags_cond_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/eflags_cond_unit_pkg.sv
// Shared types and constants for the flags/condition unit.
// Contents:
//   REG_W / reg_t   : architectural flags register width and type
//   cc_t            : x86 condition-code encoding (CC_O .. CC_G)
//   EFLAGS_RESET    : RFLAGS reset value (reserved bit 1 set)
//   EFLAGS_RSVD1    : mask of the always-one reserved bit
// The `EFLAGS_* bit-position macros normally come from the common params;
// they are provided here only when not already defined.

`ifndef EFLAGS_CF
`define EFLAGS_CF 0
`endif
`ifndef EFLAGS_PF
`define EFLAGS_PF 2
`endif
`ifndef EFLAGS_AF
`define EFLAGS_AF 4
`endif
`ifndef EFLAGS_ZF
`define EFLAGS_ZF 6
`endif
`ifndef EFLAGS_SF
`define EFLAGS_SF 7
`endif
`ifndef EFLAGS_OF
`define EFLAGS_OF 11
`endif

package eflags_cond_unit_pkg;

  localparam int unsigned REG_W = 64;

  typedef logic [REG_W-1:0] reg_t;

  // x86 Jcc/SETcc/CMOVcc low nibble; odd codes are the negated form.
  typedef enum logic [3:0] {
    CC_O  = 4'h0,
    CC_NO = 4'h1,
    CC_B  = 4'h2,
    CC_NB = 4'h3,
    CC_E  = 4'h4,
    CC_NE = 4'h5,
    CC_BE = 4'h6,
    CC_A  = 4'h7,
    CC_S  = 4'h8,
    CC_NS = 4'h9,
    CC_P  = 4'hA,
    CC_NP = 4'hB,
    CC_L  = 4'hC,
    CC_GE = 4'hD,
    CC_LE = 4'hE,
    CC_G  = 4'hF
  } cc_t;

  localparam reg_t EFLAGS_RESET = 64'h2;
  localparam reg_t EFLAGS_RSVD1 = 64'h2;

endpackage

// File: rtl/eflags_cond_unit_cond_eval.sv
// cond_eval: combinational x86 condition-code evaluator.
// Shared with the CMOV path, so it stays free of any state.
// Ports:
//   cc    in  cc_t   condition code to evaluate
//   flags in  reg_t  flags value the condition is tested against
//   taken out 1      condition is true
// Uses the `EFLAGS_* bit-position macros for flag extraction.

module cond_eval
  import eflags_cond_unit_pkg::*;
(
  input  cc_t  cc,
  input  reg_t flags,
  output logic taken
);

  logic cf;
  logic pf;
  logic zf;
  logic sf;
  logic of;
  logic lt;
  logic unused_flags;

  assign cf = flags[`EFLAGS_CF];
  assign pf = flags[`EFLAGS_PF];
  assign zf = flags[`EFLAGS_ZF];
  assign sf = flags[`EFLAGS_SF];
  assign of = flags[`EFLAGS_OF];

  // Signed less-than term shared by L/GE/LE/G.
  assign lt = sf ^ of;

  // Only a handful of bits are architecturally tested here.
  assign unused_flags = ^flags;

  always_comb begin
    taken = 1'b0;
    case (cc)
      CC_O:    taken = of;
      CC_NO:   taken = ~of;
      CC_B:    taken = cf;
      CC_NB:   taken = ~cf;
      CC_E:    taken = zf;
      CC_NE:   taken = ~zf;
      CC_BE:   taken = cf | zf;
      CC_A:    taken = ~(cf | zf);
      CC_S:    taken = sf;
      CC_NS:   taken = ~sf;
      CC_P:    taken = pf;
      CC_NP:   taken = ~pf;
      CC_L:    taken = lt;
      CC_GE:   taken = ~lt;
      CC_LE:   taken = zf | lt;
      CC_G:    taken = ~(zf | lt);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/eflags_cond_unit.sv
// eflags_cond_unit: owns architectural RFLAGS, tracks in-flight flag
// writers and resolves Jcc/SETcc/CMOVcc condition requests over a
// valid/ready handshake with a one-cycle response latency.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    clears pending count, drops held response
//   eflags_update/eflags_in  ALU flag write
//   pend_inc                 issue dispatched a flag writer this cycle
//   eflags_as_src            current flags back to the ALU
//   cond_valid/ready/code/tag  condition request channel
//   res_valid/ready/taken/tag  condition response channel
//   pend_err                 sticky pending-counter overflow
// Optional feature: define EFLAGS_BYPASS_EN for same-cycle forwarding of
// the ALU flag write to eflags_as_src and to condition evaluation.

module eflags_cond_unit
  import eflags_cond_unit_pkg::*;
#(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned PEND_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             eflags_update,
  input  reg_t             eflags_in,
  input  logic             pend_inc,
  output reg_t             eflags_as_src,
  input  logic             cond_valid,
  output logic             cond_ready,
  input  logic [3:0]       cond_code,
  input  logic [TAG_W-1:0] cond_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [TAG_W-1:0] res_tag,
  output logic             pend_err
);

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = '0;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  reg_t              flags_q;
  reg_t              flags_d;
  logic [PEND_W-1:0] pend_cnt_q;
  logic [PEND_W-1:0] pend_cnt_d;
  logic              pend_err_q;
  logic              pend_err_d;
  logic              res_valid_q;
  logic              res_valid_d;
  logic              res_taken_q;
  logic              res_taken_d;
  logic [TAG_W-1:0]  res_tag_q;
  logic [TAG_W-1:0]  res_tag_d;

  reg_t              eval_flags;
  logic              flags_clear;
  logic              accept;
  logic              eval_taken;

  // Architectural flags write; reserved bit 1 always reads as one.
  always_comb begin
    flags_d = flags_q;
    if (eflags_update) begin
      flags_d = eflags_in | EFLAGS_RSVD1;
    end
  end

  // In-flight flag-writer tracking; saturates at both ends.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    pend_err_d = pend_err_q;
    if (flush) begin
      pend_cnt_d = PEND_ZERO;
    end else if (pend_inc && !eflags_update) begin
      if (pend_cnt_q == PEND_MAX) begin
        pend_err_d = 1'b1;
      end else begin
        pend_cnt_d = pend_cnt_q + PEND_ONE;
      end
    end else if (eflags_update && !pend_inc) begin
      if (pend_cnt_q != PEND_ZERO) begin
        pend_cnt_d = pend_cnt_q - PEND_ONE;
      end
    end
  end

`ifdef EFLAGS_BYPASS_EN
  // The last outstanding writer retiring this cycle is forwarded directly.
  assign eval_flags    = eflags_update ? (eflags_in | EFLAGS_RSVD1) : flags_q;
  assign eflags_as_src = eval_flags;
  assign flags_clear   = (pend_cnt_q == PEND_ZERO) ||
                         ((pend_cnt_q == PEND_ONE) && eflags_update && !pend_inc);
`else
  assign eval_flags    = flags_q;
  assign eflags_as_src = flags_q;
  assign flags_clear   = (pend_cnt_q == PEND_ZERO);
`endif

  // Accept only with settled flags and room in the single response slot.
  assign cond_ready = flags_clear && (!res_valid_q || res_ready) && !flush;
  assign accept     = cond_valid && cond_ready;

  cond_eval u_cond_eval (
    .cc    (cc_t'(cond_code)),
    .flags (eval_flags),
    .taken (eval_taken)
  );

  // Single-entry response slot; a new accept may refill it as it drains.
  always_comb begin
    res_valid_d = res_valid_q;
    res_taken_d = res_taken_q;
    res_tag_d   = res_tag_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (accept) begin
      res_valid_d = 1'b1;
      res_taken_d = eval_taken;
      res_tag_d   = cond_tag;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= EFLAGS_RESET;
      pend_cnt_q  <= PEND_ZERO;
      pend_err_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      flags_q     <= flags_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_err_q  <= pend_err_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign res_tag   = res_tag_q;
  assign pend_err  = pend_err_q;

endmodule
